// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared constants and helpers for the push-button debouncer array.
//   DB_N_CH, DB_STABLE_CYCLES, DB_SYNC_STAGES : default parameter values
//   ST_IDLE / ST_COUNTING                     : per-channel state encodings
//   db_cnt_width(n)                           : stability counter width
// -----------------------------------------------------------------------------
package debounce_pkg;

   localparam int DB_N_CH          = 4;
   localparam int DB_STABLE_CYCLES = 16;
   localparam int DB_SYNC_STAGES   = 2;

   // The state is never stored; it is derived each cycle from s vs. level.
   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_COUNTING = 1'b1;

   // Counter only has to reach STABLE_CYCLES-1, so $clog2(n) bits suffice.
   // Clamp to 1 so a degenerate n still yields a legal vector.
   function automatic int db_cnt_width(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debouncer lane: optional inversion, N-flop synchroniser, stability
// counter, debounced level and single-cycle edge pulses.
// Ports:
//   clk    in  : system clock, rising edge
//   rst_n  in  : asynchronous active-low reset
//   pb_raw in  : raw asynchronous button input
//   level  out : debounced level (registered)
//   rise   out : one-cycle pulse on level 0->1 (registered)
//   fall   out : one-cycle pulse on level 1->0 (registered)
//   rise_d out : next-cycle value of rise, lets the parent register an OR
//                of all lanes in the same cycle as rise
// -----------------------------------------------------------------------------
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DB_SYNC_STAGES,
   parameter int ACTIVE_LOW    = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pb_raw,
   output logic level,
   output logic rise,
   output logic fall,
   output logic rise_d
);

   localparam int              CW       = db_cnt_width(STABLE_CYCLES);
   localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic                   pb_norm;
   logic [SYNC_STAGES-1:0] sync_chain;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic                   level_nxt;
   logic                   fall_d;
   logic [0:0]             state;

   // Normalise polarity before synchronising so "pressed" is always 1.
   assign pb_norm = (ACTIVE_LOW != 0) ? ~pb_raw : pb_raw;
   assign s       = sync_chain[SYNC_STAGES-1];

   // ---- stage boundary: synchroniser ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_chain <= '0;
      end else begin
         sync_chain <= {sync_chain[SYNC_STAGES-2:0], pb_norm};
      end
   end

   always_comb begin
      cnt_nxt   = cnt;
      level_nxt = level;
      rise_d    = 1'b0;
      fall_d    = 1'b0;
      state     = (s == level) ? ST_IDLE : ST_COUNTING;
      case (state)
         ST_IDLE: begin
            // Any partial mismatch streak is thrown away.
            cnt_nxt = '0;
         end
         default: begin
            if (cnt == CNT_LAST) begin
               // Held long enough: accept the new level and clear.
               level_nxt = s;
               cnt_nxt   = '0;
               rise_d    = s;
               fall_d    = ~s;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
      endcase
   end

   // ---- stage boundary: counter, level and pulse registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         level <= level_nxt;
         rise  <= rise_d;
         fall  <= fall_d;
      end
   end

endmodule

// File: rtl/pb_debounce_array.sv
// -----------------------------------------------------------------------------
// pb_debounce_array
// Multi-channel push-button debouncer for the ALU board front end. Each
// channel is an independent debounce_channel; rise pulses are also OR-ed
// into a registered any_rise aligned with pb_rise.
// Ports:
//   Clk      in        : system clock, rising edge
//   Reset    in        : asynchronous active-low reset (0 = reset)
//   pb_in    in  N_CH  : raw asynchronous button inputs
//   pb_level out N_CH  : debounced levels
//   pb_rise  out N_CH  : one-cycle pulses on level 0->1
//   pb_fall  out N_CH  : one-cycle pulses on level 1->0
//   any_rise out 1     : OR of pb_rise, same cycle
// -----------------------------------------------------------------------------
module pb_debounce_array
   import debounce_pkg::*;
#(
   parameter int N_CH          = DB_N_CH,
   parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
   parameter int SYNC_STAGES   = DB_SYNC_STAGES,
   parameter int PB_ACTIVE_LOW = 0
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic [N_CH-1:0] pb_in,
   output logic [N_CH-1:0] pb_level,
   output logic [N_CH-1:0] pb_rise,
   output logic [N_CH-1:0] pb_fall,
   output logic            any_rise
);

   logic [N_CH-1:0] rise_d;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_channel #(
         .STABLE_CYCLES (STABLE_CYCLES),
         .SYNC_STAGES   (SYNC_STAGES),
         .ACTIVE_LOW    (PB_ACTIVE_LOW)
      ) u_ch (
         .clk    (Clk),
         .rst_n  (Reset),
         .pb_raw (pb_in[i]),
         .level  (pb_level[i]),
         .rise   (pb_rise[i]),
         .fall   (pb_fall[i]),
         .rise_d (rise_d[i])
      );
   end

   // ---- stage boundary: registered OR of next-cycle rise pulses ----
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         any_rise <= 1'b0;
      end else begin
         any_rise <= |rise_d;
      end
   end

endmodule

// File: tb/tb_pb_debounce_array.sv
// -----------------------------------------------------------------------------
// tb_pb_debounce_array
// Table-driven bench for pb_debounce_array (N_CH=4, STABLE_CYCLES=8,
// SYNC_STAGES=2). Vector i is driven just after clock edge i and holds the
// outputs expected right after that same edge; the driver pushes each
// expectation into a scoreboard queue and a negedge checker pops it.
// A second instance in active-low mode is exercised by a hand sequence.
// -----------------------------------------------------------------------------
module tb_pb_debounce_array;

   typedef struct {
      logic       rst_n;
      logic [3:0] pb;
      logic [3:0] lvl;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       any;
      int         tag;
   } vec_t;

   logic       Clk;
   logic       Reset;
   logic [3:0] pb_in;
   logic [3:0] pb_level;
   logic [3:0] pb_rise;
   logic [3:0] pb_fall;
   logic       any_rise;

   logic [3:0] pb_in_al;
   logic [3:0] al_level;
   logic [3:0] al_rise;
   logic [3:0] al_fall;
   logic       al_any;

   int   checks   = 0;
   int   failures = 0;
   int   cur_tag  = 0;
   vec_t vecs[$];
   vec_t sb[$];

   pb_debounce_array #(
      .N_CH(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .PB_ACTIVE_LOW(0)
   ) dut (
      .Clk      (Clk),
      .Reset    (Reset),
      .pb_in    (pb_in),
      .pb_level (pb_level),
      .pb_rise  (pb_rise),
      .pb_fall  (pb_fall),
      .any_rise (any_rise)
   );

   pb_debounce_array #(
      .N_CH(4), .STABLE_CYCLES(8), .SYNC_STAGES(2), .PB_ACTIVE_LOW(1)
   ) dut_al (
      .Clk      (Clk),
      .Reset    (Reset),
      .pb_in    (pb_in_al),
      .pb_level (al_level),
      .pb_rise  (al_rise),
      .pb_fall  (al_fall),
      .any_rise (al_any)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string name, input int tag,
                      input logic [3:0] got, input logic [3:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s test=%0d t=%0t got=%h exp=%h", name, tag, $time, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] pb, input logic [3:0] lvl,
                      input logic [3:0] rise, input logic [3:0] fall, input int n);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.rst_n = r;
         v.pb    = pb;
         v.lvl   = lvl;
         v.rise  = rise;
         v.fall  = fall;
         v.any   = |rise;
         v.tag   = cur_tag;
         vecs.push_back(v);
      end
   endtask

   // Scoreboard checker: one expectation per clock, compared at the negedge.
   always @(negedge Clk) begin
      vec_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("level", e.tag, pb_level, e.lvl);
         chk("rise",  e.tag, pb_rise,  e.rise);
         chk("fall",  e.tag, pb_fall,  e.fall);
         chk("any",   e.tag, {3'b000, any_rise}, {3'b000, e.any});
      end
   end

   initial begin
      Reset    = 1'b0;
      pb_in    = 4'hF;
      pb_in_al = 4'hF;

      // 1: held in reset with all inputs active, then release.
      cur_tag = 1;
      add(1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 5);
      add(1'b1, 4'hF, 4'h0, 4'h0, 4'h0, 10);
      add(1'b1, 4'hF, 4'hF, 4'hF, 4'h0, 1);
      add(1'b1, 4'hF, 4'hF, 4'h0, 4'h0, 3);
      add(1'b1, 4'h0, 4'hF, 4'h0, 4'h0, 10);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'hF, 1);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3);

      // 2: clean press on ch0 at edge 0, release at edge 40.
      cur_tag = 2;
      add(1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 10);
      add(1'b1, 4'h1, 4'h1, 4'h1, 4'h0, 1);
      add(1'b1, 4'h1, 4'h1, 4'h0, 4'h0, 29);
      add(1'b1, 4'h0, 4'h1, 4'h0, 4'h0, 10);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h1, 1);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3);

      // 3: ch1 toggles every 3 clocks for 30 clocks, then settles high.
      cur_tag = 3;
      for (int i = 0; i < 30; i++)
         add(1'b1, (((i / 3) % 2) == 0) ? 4'h2 : 4'h0, 4'h0, 4'h0, 4'h0, 1);
      add(1'b1, 4'h2, 4'h0, 4'h0, 4'h0, 10);
      add(1'b1, 4'h2, 4'h2, 4'h2, 4'h0, 1);
      add(1'b1, 4'h2, 4'h2, 4'h0, 4'h0, 3);
      add(1'b1, 4'h0, 4'h2, 4'h0, 4'h0, 10);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 1);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3);

      // 4: ch2 7-clock pulse rejected, 8-clock pulse accepted.
      cur_tag = 4;
      add(1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 7);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 12);
      add(1'b1, 4'h4, 4'h0, 4'h0, 4'h0, 8);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2);
      add(1'b1, 4'h0, 4'h4, 4'h4, 4'h0, 1);
      add(1'b1, 4'h0, 4'h4, 4'h0, 4'h0, 7);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h4, 1);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3);

      // 5: ch3 and ch0 rise together.
      cur_tag = 5;
      add(1'b1, 4'h9, 4'h0, 4'h0, 4'h0, 10);
      add(1'b1, 4'h9, 4'h9, 4'h9, 4'h0, 1);
      add(1'b1, 4'h9, 4'h9, 4'h0, 4'h0, 3);
      add(1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 10);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h9, 1);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3);

      // 6: ch3 already high, ch0 counting, reset 5 clocks in.
      cur_tag = 6;
      add(1'b1, 4'h8, 4'h0, 4'h0, 4'h0, 10);
      add(1'b1, 4'h8, 4'h8, 4'h8, 4'h0, 1);
      add(1'b1, 4'h8, 4'h8, 4'h0, 4'h0, 3);
      add(1'b1, 4'h9, 4'h8, 4'h0, 4'h0, 5);
      add(1'b0, 4'h9, 4'h0, 4'h0, 4'h0, 3);
      add(1'b1, 4'h9, 4'h0, 4'h0, 4'h0, 10);
      add(1'b1, 4'h9, 4'h9, 4'h9, 4'h0, 1);
      add(1'b1, 4'h9, 4'h9, 4'h0, 4'h0, 3);
      add(1'b1, 4'h0, 4'h9, 4'h0, 4'h0, 10);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h9, 1);
      add(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 3);

      // Drive: after each edge apply the vector and queue its expectation.
      foreach (vecs[i]) begin
         @(posedge Clk);
         #1;
         Reset = vecs[i].rst_n;
         pb_in = vecs[i].pb;
         sb.push_back(vecs[i]);
      end
      @(negedge Clk);
      #1;
      chk("sb_drain", 0, sb.size() == 0 ? 4'h0 : 4'h1, 4'h0);

      // 7: active-low instance, ch0 pulled low at edge 0.
      @(posedge Clk);
      #1;
      pb_in_al = 4'hE;
      for (int k = 0; k < 14; k++) begin
         if (k > 0) @(posedge Clk);
         @(negedge Clk);
         chk("al_level", 7, al_level, (k >= 10) ? 4'h1 : 4'h0);
         chk("al_rise",  7, al_rise,  (k == 10) ? 4'h1 : 4'h0);
         chk("al_fall",  7, al_fall,  4'h0);
         chk("al_any",   7, {3'b000, al_any}, (k == 10) ? 4'h1 : 4'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
